// File: rtl/spram_frame_arbiter.sv
// ---------------------------------------------------------------------------
// spram_frame_arbiter
//
// Arbitrates the single port of the four-bank SP256K frame buffer between
// the camera capture path (writes) and the VGA scan-out path (reads), all on
// the 25 MHz pixel clock.
//
// Capture words are buffered in a small FIFO and written to sequential frame
// addresses. VGA reads always win the SPRAM slot and return data a fixed two
// cycles after the request. A frame is filled after frame_start and
// completes when the last frame word has been issued to the SPRAM.
//
// Parameters
//   FRAME_WORDS  16-bit words per frame (640x480 at 1 bit/pixel = 19200)
//   FIFO_DEPTH   capture buffer entries, power of two, at least 2
//
// Ports
//   clk          pixel clock, every flop in the block uses it
//   rst_n        synchronous active-low reset
//   frame_start  one-cycle pulse, (re)starts a frame fill
//   wr_valid     capture word available
//   wr_data      packed pixels, bit i is pixel 16*addr+i
//   wr_ready     combinational, word taken when wr_valid && wr_ready
//   rd_req       single-cycle VGA read request
//   rd_addr      word address, bank = [15:14], local = [13:0]
//   rd_valid     rd_data valid this cycle (two cycles after rd_req)
//   rd_data      read word, 0 for addresses beyond the frame
//   frame_done   one-cycle pulse alongside the final frame write
//   buf_full     level, a complete frame is stored
//   ram_ad       registered SPRAM local address shared by all banks
//   ram_di       registered SPRAM write data
//   ram_we       registered one-hot per-bank write enable
//   ram_do       bank read data, bank b on [16b+15:16b]
// ---------------------------------------------------------------------------
module spram_frame_arbiter #(
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        frame_done,
    output logic        buf_full,
    output logic [13:0] ram_ad,
    output logic [15:0] ram_di,
    output logic [3:0]  ram_we,
    input  logic [63:0] ram_do
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     FRAME_LEN = 16'(FRAME_WORDS);
    localparam logic [15:0]     LAST_WORD = 16'(FRAME_WORDS - 1);
    localparam logic [PTR_W:0]  PTR_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Capture FIFO: one extra pointer bit tells full from empty.
    logic [15:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] fifo_wptr;
    logic [PTR_W:0] fifo_rptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic [15:0]    fifo_head;

    // wr_ptr counts words issued to SPRAM, acc_cnt counts words accepted.
    logic [15:0]    wr_ptr;
    logic [15:0]    acc_cnt;

    logic           push;
    logic           pop;
    logic           last_write;

    // Read pipeline: bank and out-of-range flag travel alongside the SPRAM
    // access so the output mux picks the right bank when data arrives.
    logic           s1_valid;
    logic [1:0]     s1_bank;
    logic           s1_oor;
    logic           s2_valid;
    logic [1:0]     s2_bank;
    logic           s2_oor;
    logic [15:0]    bank_word;

    assign fifo_empty = (fifo_wptr == fifo_rptr);
    assign fifo_full  = (fifo_wptr[PTR_W] != fifo_rptr[PTR_W]) &&
                        (fifo_wptr[PTR_W-1:0] == fifo_rptr[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[fifo_rptr[PTR_W-1:0]];
    assign push       = wr_valid && wr_ready;
    assign bank_word  = ram_do[{s2_bank, 4'b0000} +: 16];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, capture handshake and write-slot decision. A write only
    // gets the slot when no read is requested; it is also held off on a
    // frame_start cycle because the restart throws away the buffered words
    // and rewinds the address.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        pop        = 1'b0;
        last_write = 1'b0;
        case (state)
            IDLE: begin
            end
            FILL: begin
                wr_ready = !fifo_full && (acc_cnt < FRAME_LEN) && !frame_start;
                pop      = !rd_req && !fifo_empty && !frame_start;
                if (pop && (wr_ptr == LAST_WORD)) begin
                    last_write = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (frame_start) begin
            state_next = FILL;
        end
    end

    // FIFO storage is not reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wptr[PTR_W-1:0]] <= wr_data;
        end
    end

    // FIFO pointers and frame counters. frame_start flushes everything so
    // the new frame begins at word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wptr <= '0;
            fifo_rptr <= '0;
            wr_ptr    <= '0;
            acc_cnt   <= '0;
        end else if (frame_start) begin
            fifo_wptr <= '0;
            fifo_rptr <= '0;
            wr_ptr    <= '0;
            acc_cnt   <= '0;
        end else begin
            if (push) begin
                fifo_wptr <= fifo_wptr + PTR_ONE;
                acc_cnt   <= acc_cnt + 16'd1;
            end
            if (pop) begin
                fifo_rptr <= fifo_rptr + PTR_ONE;
                wr_ptr    <= wr_ptr + 16'd1;
            end
        end
    end

    // SPRAM port registers. Reads own the slot whenever requested; an idle
    // slot keeps address and data so the SPRAM inputs do not toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_ad <= '0;
            ram_di <= '0;
            ram_we <= '0;
        end else if (rd_req) begin
            ram_ad <= rd_addr[13:0];
            ram_we <= '0;
        end else if (pop) begin
            ram_ad <= wr_ptr[13:0];
            ram_di <= fifo_head;
            ram_we <= 4'b0001 << wr_ptr[15:14];
        end else begin
            ram_we <= '0;
        end
    end

    // Read return path: stage 1 lines up with ram_ad, stage 2 with the
    // SPRAM output register, and the final register drives rd_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            s1_oor   <= 1'b0;
            s2_valid <= 1'b0;
            s2_bank  <= '0;
            s2_oor   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_req;
            s1_bank  <= rd_addr[15:14];
            s1_oor   <= (rd_addr >= FRAME_LEN);
            s2_valid <= s1_valid;
            s2_bank  <= s1_bank;
            s2_oor   <= s1_oor;
            rd_valid <= s2_valid;
            if (s2_valid) begin
                rd_data <= s2_oor ? 16'h0000 : bank_word;
            end
        end
    end

    // Frame completion: frame_done coincides with the final ram_we, and
    // buf_full stays up until the next frame_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            buf_full   <= 1'b0;
        end else begin
            frame_done <= last_write;
            if (frame_start) begin
                buf_full <= 1'b0;
            end else if (last_write) begin
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spram_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_frame_arbiter
//
// Two instances of the arbiter share one clock:
//   dut     FRAME_WORDS = 8, exercised by directed sequences and random
//           traffic, compared every cycle with a queue-based frame model.
//   dut_big FRAME_WORDS = 51968 so that 16'h8005 lies inside the frame and
//           bank 3 local >= 2816 lies beyond it; read-only banking table.
// Each instance has its own behavioural SPRAM (four 16K x 16 banks).
// ---------------------------------------------------------------------------
module tb_spram_frame_arbiter;

    localparam int SM_WORDS  = 8;
    localparam int DEPTH     = 4;
    localparam int BIG_WORDS = 51968;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Small instance signals
    logic        rst_n, frame_start, wr_valid, wr_ready, rd_req, rd_valid;
    logic        frame_done, buf_full;
    logic [15:0] wr_data, rd_addr, rd_data, ram_di;
    logic [13:0] ram_ad;
    logic [3:0]  ram_we;
    logic [63:0] ram_do;

    // Large instance signals
    logic        rst_b, frame_start_b, wr_valid_b, wr_ready_b, rd_req_b, rd_valid_b;
    logic        frame_done_b, buf_full_b;
    logic [15:0] wr_data_b, rd_addr_b, rd_data_b, ram_di_b;
    logic [13:0] ram_ad_b;
    logic [3:0]  ram_we_b;
    logic [63:0] ram_do_b;

    spram_frame_arbiter #(.FRAME_WORDS(SM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .frame_done(frame_done), .buf_full(buf_full),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do)
    );

    spram_frame_arbiter #(.FRAME_WORDS(BIG_WORDS), .FIFO_DEPTH(DEPTH)) dut_big (
        .clk(clk), .rst_n(rst_b), .frame_start(frame_start_b),
        .wr_valid(wr_valid_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .frame_done(frame_done_b), .buf_full(buf_full_b),
        .ram_ad(ram_ad_b), .ram_di(ram_di_b), .ram_we(ram_we_b), .ram_do(ram_do_b)
    );

    // Behavioural SPRAM for the small instance: write or read each edge.
    logic [15:0] sm_mem [4][16384];
    logic [15:0] sm_do  [4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) sm_mem[b][ram_ad] <= ram_di;
            else           sm_do[b] <= sm_mem[b][ram_ad];
        end
    end
    assign ram_do = {sm_do[3], sm_do[2], sm_do[1], sm_do[0]};

    // Preloaded read-only SPRAM for the large instance.
    logic [15:0] big_mem [4][16384];
    logic [15:0] big_do  [4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) big_do[b] <= big_mem[b][ram_ad_b];
    end
    assign ram_do_b = {big_do[3], big_do[2], big_do[1], big_do[0]};

    // Scoreboard counters
    int checks = 0;
    int errors = 0;

    // Frame model: a queue for buffered words, linear frame memory, and a
    // schedule of expected read returns keyed by cycle number.
    bit          m_filling = 0;
    bit          m_full    = 0;
    int          m_ptr     = 0;
    int          m_acc     = 0;
    logic [15:0] m_q [$];
    logic [15:0] m_mem [SM_WORDS];
    logic [15:0] rd_sched [int];
    logic [3:0]  exp_we = '0;
    logic [13:0] exp_ad = '0;
    logic [15:0] exp_di = '0;
    bit          exp_fd = 0;
    int          cyc = 0;
    bit          primed = 0;
    int          fd_seen = 0;
    int          dut_accepts = 0;
    logic        last_ready;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } rd_vec_t;
    rd_vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        bit exp_rv;
        exp_rv = rd_sched.exists(cyc);
        check("ram_we", ram_we, exp_we);
        check("ram_ad", ram_ad, exp_ad);
        check("ram_di", ram_di, exp_di);
        check("frame_done", frame_done, exp_fd);
        check("buf_full", buf_full, m_full);
        check("rd_valid", rd_valid, exp_rv);
        if (exp_rv) begin
            check("rd_data", rd_data, rd_sched[cyc]);
            rd_sched.delete(cyc);
        end
        if (frame_done === 1'b1) fd_seen++;
    endtask

    // One clock cycle on the small instance: drive, check wr_ready, advance
    // the model across the edge, then compare registered outputs.
    task automatic applyStimulus(input bit fs, input bit wv, input logic [15:0] wd,
                                 input bit rr, input logic [15:0] ra, input bit rn);
        bit          exp_rdy;
        logic [15:0] word;
        @(negedge clk);
        frame_start = fs;
        wr_valid    = wv;
        wr_data     = wd;
        rd_req      = rr;
        rd_addr     = ra;
        rst_n       = rn;
        #1;
        exp_rdy    = m_filling && (m_q.size() < DEPTH) && (m_acc < SM_WORDS) && !fs;
        last_ready = wr_ready;
        if (primed) check("wr_ready", wr_ready, exp_rdy);
        if (wv && rn && wr_ready === 1'b1) dut_accepts++;
        @(posedge clk);
        primed = 1;
        cyc++;
        exp_fd = 0;
        if (!rn) begin
            m_filling = 0;
            m_full    = 0;
            m_ptr     = 0;
            m_acc     = 0;
            m_q.delete();
            exp_we = '0;
            exp_ad = '0;
            exp_di = '0;
            rd_sched.delete(cyc);
            rd_sched.delete(cyc + 1);
        end else begin
            if (rr) begin
                exp_we = '0;
                exp_ad = ra[13:0];
                rd_sched[cyc + 2] = (ra < SM_WORDS) ? m_mem[ra] : 16'h0000;
            end else if (m_filling && m_q.size() > 0 && !fs) begin
                word   = m_q.pop_front();
                exp_we = 4'(1 << (m_ptr / 16384));
                exp_ad = 14'(m_ptr % 16384);
                exp_di = word;
                m_mem[m_ptr] = word;
                m_ptr++;
                if (m_ptr == SM_WORDS) begin
                    m_filling = 0;
                    m_full    = 1;
                    exp_fd    = 1;
                end
            end else begin
                exp_we = '0;
            end
            if (fs) begin
                m_q.delete();
                m_ptr     = 0;
                m_acc     = 0;
                m_full    = 0;
                m_filling = 1;
            end else if (wv && exp_rdy) begin
                m_q.push_back(wd);
                m_acc++;
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 0; frame_start = 0; wr_valid = 0; wr_data = 0; rd_req = 0; rd_addr = 0;
        rst_b = 0; frame_start_b = 0; wr_valid_b = 0; wr_data_b = 0; rd_req_b = 0; rd_addr_b = 0;
        for (int i = 0; i < SM_WORDS; i++) m_mem[i] = 16'h0000;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16384; a++) big_mem[b][a] = 16'h0000;
        big_mem[2][5]     = 16'hA5C3;
        big_mem[0][0]     = 16'h1111;
        big_mem[1][16383] = 16'hBEEF;
        big_mem[3][2815]  = 16'hCAFE;
        big_mem[3][2816]  = 16'hDEAD;
        big_mem[3][16383] = 16'hF00D;
        big_mem[0][5]     = 16'h0505;
        big_mem[1][5]     = 16'h1515;
        big_mem[3][5]     = 16'h3535;
        big_mem[1][1]     = 16'h2222;

        vecs[0] = '{16'h8005, 16'hA5C3};
        vecs[1] = '{16'h0000, 16'h1111};
        vecs[2] = '{16'h7FFF, 16'hBEEF};
        vecs[3] = '{16'hCAFF, 16'hCAFE};
        vecs[4] = '{16'hCB00, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'h0000};
        vecs[6] = '{16'h0005, 16'h0505};
        vecs[7] = '{16'h4005, 16'h1515};
        vecs[8] = '{16'hC005, 16'h3535};
        vecs[9] = '{16'h4001, 16'h2222};

        // Reset held three cycles with traffic on the inputs
        repeat (3) applyStimulus(0, 1, 16'h5555, 1, 16'h0003, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_ram_ad", ram_ad, 0);
        check("reset_ram_di", ram_di, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_buf_full", buf_full, 0);
        rst_b = 1;

        // Full 8-word fill without reads, then read the frame back
        fd_seen = 0;
        applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 1);
        for (int i = 0; i < SM_WORDS; i++)
            applyStimulus(0, 1, 16'h1000 + 16'(i * 16'h0111), 0, 16'h0000, 1);
        repeat (3) applyStimulus(0, 1, 16'hFFFF, 0, 16'h0000, 1);
        check("fill_frame_done_pulses", fd_seen, 1);
        check("fill_buf_full", buf_full, 1);
        check("fill_wr_ready_after", wr_ready, 0);
        for (int i = 0; i < SM_WORDS; i++)
            applyStimulus(0, 0, 16'h0000, 1, 16'(i), 1);
        applyStimulus(0, 0, 16'h0000, 1, 16'h0008, 1);
        applyStimulus(0, 0, 16'h0000, 1, 16'hFFFF, 1);
        repeat (3) applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 1);

        // Contention: reads every cycle starve writes, FIFO fills
        applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 1);
        dut_accepts = 0;
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 16'hC000 + 16'(i), 1, 16'h0001, 1);
        check("contention_accepts", dut_accepts, DEPTH);
        repeat (6) applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 1);

        // Restart mid-fill with a beat offered alongside frame_start
        applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 16'hD000 + 16'(i), 1, 16'h0002, 1);
        applyStimulus(1, 1, 16'hEEEE, 0, 16'h0000, 1);
        check("restart_beat_refused", last_ready, 0);
        applyStimulus(0, 1, 16'hBEEF, 0, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 1);
        check("restart_we", ram_we, 4'b0001);
        check("restart_ad", ram_ad, 0);
        check("restart_di", ram_di, 16'hBEEF);
        check("restart_buf_full", buf_full, 0);
        repeat (2) applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 1);

        // Reset after three writes of a frame
        applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 16'hA000 + 16'(i), 0, 16'h0000, 1);
        applyStimulus(0, 1, 16'hA004, 0, 16'h0000, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 16'hA005 + 16'(i), 0, 16'h0000, 1);
            check("midreset_no_we", ram_we, 0);
            check("midreset_not_ready", last_ready, 0);
        end

        // Random traffic against the frame model
        for (int n = 0; n < 1500; n++) begin
            bit          fs, wv, rr, rn;
            logic [15:0] ra;
            fs = ($urandom % 50) == 0;
            rn = ($urandom % 150) != 0;
            wv = ($urandom % 10) < 7;
            rr = ($urandom % 10) < 3;
            ra = (($urandom % 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 11));
            applyStimulus(fs, wv, 16'($urandom), rr, ra, rn);
        end
        repeat (3) applyStimulus(0, 0, 16'h0000, 0, 16'h0000, 1);

        // Banking table on the large instance: isolated reads, exact latency
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            rd_req_b  = 1;
            rd_addr_b = vecs[v].addr;
            @(negedge clk);
            rd_req_b  = 0;
            rd_addr_b = 16'h0000;
            @(posedge clk); #1;
            check("big_latency_early", rd_valid_b, 0);
            @(posedge clk); #1;
            check("big_rd_valid", rd_valid_b, 1);
            check("big_rd_data", rd_data_b, vecs[v].data);
            @(posedge clk); #1;
            check("big_rd_valid_one_cycle", rd_valid_b, 0);
        end

        // Same table issued back to back at full rate
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            rd_req_b  = (e < 10);
            rd_addr_b = (e < 10) ? vecs[e].addr : 16'h0000;
            @(posedge clk); #1;
            check("big_b2b_no_write", ram_we_b, 0);
            if (e >= 2) begin
                check("big_b2b_valid", rd_valid_b, 1);
                check("big_b2b_data", rd_data_b, vecs[e - 2].data);
            end else begin
                check("big_b2b_idle", rd_valid_b, 0);
            end
        end
        @(negedge clk);
        rd_req_b = 0;
        @(posedge clk); #1;
        check("big_b2b_end", rd_valid_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
